corescore_stream_arbiter: RTL and testbench
===========================================

# corescore_stream_arbiter

Packet-atomic round-robin arbiter that merges NUM_PORTS byte-wide AXI-Stream message sources into one stream feeding the emitter. It sits between the per-core message outputs of corescorecore and the emitter's single stream input. A grant, once issued, is held for a whole packet (up to and including the tlast beat), so messages from different cores never interleave on the UART. Output is fully registered; throughput inside a packet is one beat per cycle.

## Interface
- NUM_PORTS, 4, number of requesting streams (≥2)
- DW, 8, data width per beat
- i_clk  in  1  sole clock
- i_rst  in  1  synchronous reset, active-high
- i_tdata  in  NUM_PORTS*DW  port p occupies bits [p*DW +: DW]
- i_tlast  in  NUM_PORTS  last beat of packet, per port
- i_tvalid  in  NUM_PORTS  beat valid, per port
- o_tready  out  NUM_PORTS  beat accepted from port p when i_tvalid[p] & o_tready[p]
- o_tdata  out  DW  merged stream data (registered)
- o_tlast  out  1  merged stream last (registered)
- o_tvalid  out  1  merged stream valid (registered)
- i_tready  in  1  downstream (emitter) ready
- o_grant  out  NUM_PORTS  one-hot current owner, all-zero when idle
- o_busy  out  1  high in LOCKED

## Operation
- State machine, two states: IDLE, LOCKED. Registers: state, grant (one-hot), last_grant (index), output register {o_tdata, o_tlast, o_tvalid}.
- IDLE: if any i_tvalid set, select first set port searching last_grant+1, last_grant+2, … wrapping modulo NUM_PORTS; next edge: grant ← selected, state ← LOCKED. No valid → stay IDLE. o_tready all zero.
- LOCKED, granted port g: o_tready[g] = !o_tvalid | i_tready; all other o_tready bits 0.
- Input beat accepted (i_tvalid[g] & o_tready[g]): output register ← {i_tdata[g], i_tlast[g], 1}.
- Otherwise, if i_tready: o_tvalid ← 0 (o_tdata/o_tlast hold).
- Accepted beat has i_tlast[g]: next edge state ← IDLE, grant ← 0, last_grant ← g.
- Source drops i_tvalid mid-packet: lock held indefinitely; no timeout, no preemption.
- i_tvalid on non-granted ports is ignored while LOCKED; those ports are served in round-robin order afterwards.
- Zero-length packets do not exist; a single-beat packet has tlast on its only beat.

## Timing
- Reset (edge with i_rst=1): state IDLE, grant 0, last_grant NUM_PORTS-1 (port 0 wins first), o_tvalid 0, o_tdata 0, o_tlast 0; hence o_tready 0, o_grant 0, o_busy 0.
- Reset mid-packet: all of the above on the same edge; the beat held in the output register is discarded; the source's partial packet is not resumed.
- Arbitration latency: i_tvalid[p] high before edge N (idle) → o_grant[p] after N → o_tready[p] high in cycle after N → first o_tvalid after edge N+1.
- In-packet throughput: 1 beat/cycle with i_tready held high; o_tready is combinational from i_tready and o_tvalid only (no dependence on any i_tvalid).
- Inter-packet gap: exactly one IDLE cycle with o_tready all zero between tlast acceptance and next grant's first acceptance.
- Same-cycle output drain and input accept: register reloads, o_tvalid stays 1, no bubble.
- o_tdata/o_tlast stable while o_tvalid & !i_tready.

## Structure
- Package corescore_stream_pkg: state encoding (IDLE, LOCKED), default DW constant.
- Sub-module corescore_rr_picker: combinational rotating priority encoder (inputs: request vector, last_grant index; outputs: one-hot pick, pick index, any). Arbiter instantiates one.

## Test plan
- Single port: port 1 sends 0x48,0x69,0x0A (tlast on 0x0A), i_tready=1 → output 0x48,0x69,0x0A on three consecutive cycles starting two cycles after i_tvalid; o_tlast only on 0x0A; o_grant=0010 then 0000.
- Contention after reset: ports 0,2,3 each hold a 2-beat packet from cycle 0 → output order port 0, 2, 3; one gap cycle between packets.
- Wrap: after port 3 served, ports 0 and 3 request → port 0 granted.
- Atomicity: port 0 mid-packet drops i_tvalid for 5 cycles while port 1 requests → no port-1 beat appears until port 0's tlast accepted; o_grant stays 0001.
- Backpressure: i_tready low 3 cycles with o_tvalid=1, o_tdata=0x55 → o_tdata held at 0x55, o_tready[g]=0, no beat lost or duplicated when i_tready returns.
- Reset mid-packet: i_rst pulsed after 2nd of 4 beats → next cycle o_tvalid=0, o_grant=0, o_busy=0; subsequent request from port 2 granted with normal latency.

Source files
------------

// File: rtl/corescore_stream_pkg.sv
// Shared types for the corescore stream arbiter: FSM state encoding and default beat width.
package corescore_stream_pkg;

   localparam int DEFAULT_DW = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/corescore_rr_picker.sv
// Combinational rotating-priority encoder: first set request after i_last, wrapping.
module corescore_rr_picker #(
   parameter int NUM_PORTS = 4,
   parameter int IW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [IW-1:0]        i_last,
   output logic [NUM_PORTS-1:0] o_pick,
   output logic [IW-1:0]        o_pick_idx,
   output logic                 o_any
);

   // Offset 1 is checked first so the previous owner gets lowest priority.
   always_comb begin
      int idx;
      idx        = 0;
      o_pick     = '0;
      o_pick_idx = '0;
      o_any      = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = (int'(i_last) + i) % NUM_PORTS;
         if (!o_any && i_req[idx]) begin
            o_any       = 1'b1;
            o_pick[idx] = 1'b1;
            o_pick_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS byte streams into one registered stream;
// a grant is held from the first beat through the accepted tlast beat.
module corescore_stream_arbiter
   import corescore_stream_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DW        = DEFAULT_DW
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_PORTS*DW-1:0] i_tdata,
   input  logic [NUM_PORTS-1:0]    i_tlast,
   input  logic [NUM_PORTS-1:0]    i_tvalid,
   output logic [NUM_PORTS-1:0]    o_tready,
   output logic [DW-1:0]           o_tdata,
   output logic                    o_tlast,
   output logic                    o_tvalid,
   input  logic                    i_tready,
   output logic [NUM_PORTS-1:0]    o_grant,
   output logic                    o_busy
);

   localparam int IW = $clog2(NUM_PORTS);

   arb_state_e             state_q, state_d;
   logic [NUM_PORTS-1:0]   grant_q, grant_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          last_grant_q, last_grant_d;
   logic [DW-1:0]          tdata_q, tdata_d;
   logic                   tlast_q, tlast_d;
   logic                   tvalid_q, tvalid_d;

   logic [NUM_PORTS-1:0]   pick;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;
   logic [DW-1:0]          sel_data;
   logic                   sel_last;
   logic                   accept;

   corescore_rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .IW        (IW)
   ) u_picker (
      .i_req      (i_tvalid),
      .i_last     (last_grant_q),
      .o_pick     (pick),
      .o_pick_idx (pick_idx),
      .o_any      (pick_any)
   );

   // Ready depends only on the output register and downstream ready, never on any tvalid.
   always_comb begin
      o_tready = '0;
      if (state_q == LOCKED) begin
         o_tready = grant_q & {NUM_PORTS{~tvalid_q | i_tready}};
      end
      sel_data = i_tdata[int'(owner_q)*DW +: DW];
      sel_last = i_tlast[owner_q];
      accept   = |(i_tvalid & o_tready);
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      tdata_d      = tdata_q;
      tlast_d      = tlast_q;
      tvalid_d     = tvalid_q;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = LOCKED;
               grant_d = pick;
               owner_d = pick_idx;
            end
         end
         LOCKED: begin
            if (accept && sel_last) begin
               state_d      = IDLE;
               grant_d      = '0;
               last_grant_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // A drain and a load in the same cycle simply reload, keeping tvalid high.
      if (accept) begin
         tdata_d  = sel_data;
         tlast_d  = sel_last;
         tvalid_d = 1'b1;
      end else if (i_tready) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_grant_q <= IW'(NUM_PORTS - 1);
         tdata_q      <= '0;
         tlast_q      <= 1'b0;
         tvalid_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         tdata_q      <= tdata_d;
         tlast_q      <= tlast_d;
         tvalid_q     <= tvalid_d;
      end
   end

   assign o_tdata  = tdata_q;
   assign o_tlast  = tlast_q;
   assign o_tvalid = tvalid_q;
   assign o_grant  = grant_q;
   assign o_busy   = (state_q == LOCKED);

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Self-checking bench for corescore_stream_arbiter: directed scenarios plus randomized
// multi-port traffic compared against a packet-level round-robin model.
module tb_corescore_stream_arbiter;

   localparam int NUM_PORTS = 4;
   localparam int DW        = 8;

   typedef logic [DW:0] beat_t;

   logic                    i_clk = 1'b0;
   logic                    i_rst;
   logic [NUM_PORTS*DW-1:0] i_tdata;
   logic [NUM_PORTS-1:0]    i_tlast;
   logic [NUM_PORTS-1:0]    i_tvalid;
   logic [NUM_PORTS-1:0]    o_tready;
   logic [DW-1:0]           o_tdata;
   logic                    o_tlast;
   logic                    o_tvalid;
   logic                    i_tready;
   logic [NUM_PORTS-1:0]    o_grant;
   logic                    o_busy;

   beat_t src_q    [NUM_PORTS][$];
   bit    src_hold [NUM_PORTS];
   beat_t out_beats[$];
   int    out_cyc[$];
   int    cyc;
   int    checks;
   int    passes;

   corescore_stream_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .DW        (DW)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .i_tvalid (i_tvalid),
      .o_tready (o_tready),
      .o_tdata  (o_tdata),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .i_tready (i_tready),
      .o_grant  (o_grant),
      .o_busy   (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic drive_sources();
      beat_t b;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (src_q[p].size() != 0 && !src_hold[p]) begin
            b = src_q[p][0];
            i_tvalid[p]           = 1'b1;
            i_tlast[p]            = b[DW];
            i_tdata[p*DW +: DW]   = b[DW-1:0];
         end else begin
            i_tvalid[p]           = 1'b0;
            i_tlast[p]            = 1'b0;
            i_tdata[p*DW +: DW]   = '0;
         end
      end
   endtask

   task automatic step();
      @(negedge i_clk);
      #2;
   endtask

   task automatic clear_sources();
      for (int p = 0; p < NUM_PORTS; p++) begin
         src_q[p].delete();
         src_hold[p] = 1'b0;
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      clear_sources();
      drive_sources();
      step();
      step();
      i_rst = 1'b0;
      out_beats.delete();
      out_cyc.delete();
   endtask

   task automatic wait_out(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (out_beats.size() >= n) break;
         step();
      end
      if (out_beats.size() >= n) ok = 1'b1;
   endtask

   // Source presentation: refreshed every falling edge from the per-port beat queues.
   initial begin
      forever begin
         @(negedge i_clk);
         drive_sources();
      end
   end

   // Handshakes are captured just before the rising edge and retired just after it.
   initial begin
      bit    acc [NUM_PORTS];
      bit    xfer;
      beat_t ob;
      cyc = 0;
      forever begin
         @(negedge i_clk);
         #4;
         for (int p = 0; p < NUM_PORTS; p++) acc[p] = i_tvalid[p] && o_tready[p];
         xfer = o_tvalid && i_tready;
         ob   = {o_tlast, o_tdata};
         @(posedge i_clk);
         cyc++;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
         end
         if (xfer) begin
            out_beats.push_back(ob);
            out_cyc.push_back(cyc);
         end
      end
   end

   task automatic test_reset();
      $display("[TB] test_reset");
      i_rst    = 1'b1;
      i_tready = 1'b1;
      clear_sources();
      for (int p = 0; p < NUM_PORTS; p++) src_q[p].push_back({1'b1, 8'(8'hE0 + p)});
      drive_sources();
      step();
      step();
      checks++; if (o_grant !== 4'b0000) $display("[TB] FAIL reset_held_grant got=%b exp=0000", o_grant); else passes++;
      checks++; if (o_tvalid !== 1'b0) $display("[TB] FAIL reset_held_tvalid got=%b exp=0", o_tvalid); else passes++;
      clear_sources();
      drive_sources();
      i_rst = 1'b0;
      #1;
      checks++; if (o_tdata !== 8'h00) $display("[TB] FAIL reset_tdata got=%h exp=00", o_tdata); else passes++;
      checks++; if (o_tlast !== 1'b0) $display("[TB] FAIL reset_tlast got=%b exp=0", o_tlast); else passes++;
      checks++; if (o_tready !== 4'b0000) $display("[TB] FAIL reset_tready got=%b exp=0000", o_tready); else passes++;
      checks++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", o_busy); else passes++;
      step();
      checks++; if (o_grant !== 4'b0000) $display("[TB] FAIL reset_idle_grant got=%b exp=0000", o_grant); else passes++;
   endtask

   task automatic test_single_port();
      logic [3:0] exp_grant [5];
      logic       exp_valid [5];
      logic [7:0] exp_data  [5];
      logic       exp_last  [5];
      $display("[TB] test_single_port");
      exp_grant = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      exp_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_data  = '{8'h00, 8'h48, 8'h69, 8'h0A, 8'h00};
      exp_last  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      i_tready = 1'b1;
      src_q[1].push_back({1'b0, 8'h48});
      src_q[1].push_back({1'b0, 8'h69});
      src_q[1].push_back({1'b1, 8'h0A});
      drive_sources();
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (o_grant !== exp_grant[k]) $display("[TB] FAIL single_grant[%0d] got=%b exp=%b", k, o_grant, exp_grant[k]); else passes++;
         checks++; if (o_tvalid !== exp_valid[k]) $display("[TB] FAIL single_tvalid[%0d] got=%b exp=%b", k, o_tvalid, exp_valid[k]); else passes++;
         if (exp_valid[k]) begin
            checks++; if ({o_tlast, o_tdata} !== {exp_last[k], exp_data[k]}) $display("[TB] FAIL single_beat[%0d] got=%b/%h exp=%b/%h", k, o_tlast, o_tdata, exp_last[k], exp_data[k]); else passes++;
         end
         if (k == 0) begin
            checks++; if (o_tready !== 4'b0010) $display("[TB] FAIL single_tready got=%b exp=0010", o_tready); else passes++;
            checks++; if (o_busy !== 1'b1) $display("[TB] FAIL single_busy got=%b exp=1", o_busy); else passes++;
         end
      end
   endtask

   task automatic test_contention();
      beat_t exp_seq [6];
      beat_t got;
      bit    ok;
      $display("[TB] test_contention");
      exp_seq = '{9'h0A0, 9'h1A1, 9'h0C0, 9'h1C1, 9'h0D0, 9'h1D1};
      do_reset();
      i_tready = 1'b1;
      src_q[0].push_back(9'h0A0); src_q[0].push_back(9'h1A1);
      src_q[2].push_back(9'h0C0); src_q[2].push_back(9'h1C1);
      src_q[3].push_back(9'h0D0); src_q[3].push_back(9'h1D1);
      drive_sources();
      wait_out(6, 100, ok);
      checks++; if (!ok) $display("[TB] FAIL contention_timeout got=%0d beats exp=6", out_beats.size()); else passes++;
      for (int i = 0; i < 6; i++) begin
         got = (i < out_beats.size()) ? out_beats[i] : 'x;
         checks++; if (got !== exp_seq[i]) $display("[TB] FAIL contention_beat[%0d] got=%h exp=%h", i, got, exp_seq[i]); else passes++;
      end
      if (out_cyc.size() >= 6) begin
         checks++; if (out_cyc[1] - out_cyc[0] !== 1) $display("[TB] FAIL contention_inpacket_gap got=%0d exp=1", out_cyc[1] - out_cyc[0]); else passes++;
         checks++; if (out_cyc[2] - out_cyc[1] !== 2) $display("[TB] FAIL contention_gap_0_2 got=%0d exp=2", out_cyc[2] - out_cyc[1]); else passes++;
         checks++; if (out_cyc[4] - out_cyc[3] !== 2) $display("[TB] FAIL contention_gap_2_3 got=%0d exp=2", out_cyc[4] - out_cyc[3]); else passes++;
      end
   endtask

   task automatic test_wrap();
      beat_t exp_seq [3];
      beat_t got;
      bit    ok;
      $display("[TB] test_wrap");
      exp_seq = '{9'h00B, 9'h10C, 9'h13E};
      step();
      out_beats.delete();
      out_cyc.delete();
      src_q[3].push_back(9'h13E);
      src_q[0].push_back(9'h00B);
      src_q[0].push_back(9'h10C);
      drive_sources();
      wait_out(3, 100, ok);
      checks++; if (!ok) $display("[TB] FAIL wrap_timeout got=%0d beats exp=3", out_beats.size()); else passes++;
      for (int i = 0; i < 3; i++) begin
         got = (i < out_beats.size()) ? out_beats[i] : 'x;
         checks++; if (got !== exp_seq[i]) $display("[TB] FAIL wrap_beat[%0d] got=%h exp=%h", i, got, exp_seq[i]); else passes++;
      end
   endtask

   task automatic test_atomicity();
      beat_t exp_seq [6];
      beat_t got;
      bit    ok;
      $display("[TB] test_atomicity");
      exp_seq = '{9'h010, 9'h011, 9'h012, 9'h113, 9'h020, 9'h121};
      step();
      out_beats.delete();
      out_cyc.delete();
      src_q[0].push_back(9'h010); src_q[0].push_back(9'h011);
      src_q[0].push_back(9'h012); src_q[0].push_back(9'h113);
      drive_sources();
      for (int i = 0; i < 20 && src_q[0].size() > 2; i++) step();
      src_hold[0] = 1'b1;
      src_q[1].push_back(9'h020);
      src_q[1].push_back(9'h121);
      drive_sources();
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (o_grant !== 4'b0001) $display("[TB] FAIL atomic_grant[%0d] got=%b exp=0001", k, o_grant); else passes++;
         checks++; if (o_tready[1] !== 1'b0) $display("[TB] FAIL atomic_tready1[%0d] got=%b exp=0", k, o_tready[1]); else passes++;
      end
      src_hold[0] = 1'b0;
      drive_sources();
      wait_out(6, 100, ok);
      checks++; if (!ok) $display("[TB] FAIL atomic_timeout got=%0d beats exp=6", out_beats.size()); else passes++;
      for (int i = 0; i < 6; i++) begin
         got = (i < out_beats.size()) ? out_beats[i] : 'x;
         checks++; if (got !== exp_seq[i]) $display("[TB] FAIL atomic_beat[%0d] got=%h exp=%h", i, got, exp_seq[i]); else passes++;
      end
   endtask

   task automatic test_backpressure();
      beat_t exp_seq [3];
      beat_t got;
      bit    ok;
      $display("[TB] test_backpressure");
      exp_seq = '{9'h055, 9'h066, 9'h177};
      step();
      out_beats.delete();
      out_cyc.delete();
      i_tready = 1'b1;
      src_q[2].push_back(9'h055);
      src_q[2].push_back(9'h066);
      src_q[2].push_back(9'h177);
      drive_sources();
      for (int i = 0; i < 20; i++) begin
         step();
         if (o_tvalid && o_tdata == 8'h55) break;
      end
      i_tready = 1'b0;
      #1;
      checks++; if (o_tready !== 4'b0000) $display("[TB] FAIL bp_tready_drop got=%b exp=0000", o_tready); else passes++;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if ({o_tvalid, o_tdata} !== {1'b1, 8'h55}) $display("[TB] FAIL bp_hold[%0d] got=%b/%h exp=1/55", k, o_tvalid, o_tdata); else passes++;
         checks++; if (o_tready !== 4'b0000) $display("[TB] FAIL bp_tready[%0d] got=%b exp=0000", k, o_tready); else passes++;
      end
      i_tready = 1'b1;
      wait_out(3, 100, ok);
      for (int i = 0; i < 5; i++) step();
      checks++; if (out_beats.size() !== 3) $display("[TB] FAIL bp_count got=%0d exp=3", out_beats.size()); else passes++;
      for (int i = 0; i < 3; i++) begin
         got = (i < out_beats.size()) ? out_beats[i] : 'x;
         checks++; if (got !== exp_seq[i]) $display("[TB] FAIL bp_beat[%0d] got=%h exp=%h", i, got, exp_seq[i]); else passes++;
      end
   endtask

   task automatic test_reset_mid_packet();
      $display("[TB] test_reset_mid_packet");
      step();
      out_beats.delete();
      i_tready = 1'b1;
      src_q[1].push_back(9'h031); src_q[1].push_back(9'h032);
      src_q[1].push_back(9'h033); src_q[1].push_back(9'h134);
      drive_sources();
      for (int i = 0; i < 20 && src_q[1].size() > 2; i++) step();
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      clear_sources();
      drive_sources();
      #1;
      checks++; if (o_tvalid !== 1'b0) $display("[TB] FAIL rstmid_tvalid got=%b exp=0", o_tvalid); else passes++;
      checks++; if (o_grant !== 4'b0000) $display("[TB] FAIL rstmid_grant got=%b exp=0000", o_grant); else passes++;
      checks++; if (o_busy !== 1'b0) $display("[TB] FAIL rstmid_busy got=%b exp=0", o_busy); else passes++;
      src_q[2].push_back(9'h041);
      src_q[2].push_back(9'h142);
      drive_sources();
      step();
      checks++; if (o_grant !== 4'b0100) $display("[TB] FAIL rstmid_regrant got=%b exp=0100", o_grant); else passes++;
      checks++; if ({o_tvalid, o_tready} !== {1'b0, 4'b0100}) $display("[TB] FAIL rstmid_ready got=%b/%b exp=0/0100", o_tvalid, o_tready); else passes++;
      step();
      checks++; if ({o_tvalid, o_tlast, o_tdata} !== {1'b1, 1'b0, 8'h41}) $display("[TB] FAIL rstmid_first got=%b/%b/%h exp=1/0/41", o_tvalid, o_tlast, o_tdata); else passes++;
   endtask

   task automatic test_random(input int iter);
      beat_t exp_src [NUM_PORTS][$];
      beat_t exp_out [$];
      beat_t b;
      beat_t got;
      int    npk;
      int    len;
      int    last;
      int    q;
      bit    found;
      bit    prev_valid;
      bit    prev_ready;
      beat_t prev_beat;
      $display("[TB] test_random iteration %0d", iter);
      do_reset();
      for (int p = 0; p < NUM_PORTS; p++) begin
         npk = $urandom_range(1, 3);
         for (int k = 0; k < npk; k++) begin
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
               b = {1'(j == len - 1), 2'(p), 6'($urandom)};
               src_q[p].push_back(b);
               exp_src[p].push_back(b);
            end
         end
      end
      // Every pending port keeps tvalid high, so whole packets go out in plain rotation order.
      last = NUM_PORTS - 1;
      do begin
         found = 1'b0;
         for (int k = 1; k <= NUM_PORTS && !found; k++) begin
            q = (last + k) % NUM_PORTS;
            if (exp_src[q].size() != 0) begin
               do begin
                  b = exp_src[q].pop_front();
                  exp_out.push_back(b);
               end while (!b[DW]);
               last  = q;
               found = 1'b1;
            end
         end
      end while (found);
      drive_sources();
      prev_valid = 1'b0;
      prev_ready = 1'b1;
      prev_beat  = '0;
      for (int c = 0; c < 2000 && out_beats.size() < exp_out.size(); c++) begin
         i_tready = ($urandom_range(0, 3) != 0);
         prev_ready = i_tready;
         step();
         if (prev_valid && !prev_ready) begin
            checks++; if ({o_tvalid, o_tlast, o_tdata} !== {1'b1, prev_beat}) $display("[TB] FAIL rand_stable got=%b/%h exp=1/%h", o_tvalid, {o_tlast, o_tdata}, prev_beat); else passes++;
         end
         checks++; if ((o_tready & ~o_grant) !== 4'b0000) $display("[TB] FAIL rand_ready_owner got=%b grant=%b exp=subset", o_tready, o_grant); else passes++;
         prev_valid = o_tvalid;
         prev_beat  = {o_tlast, o_tdata};
      end
      checks++; if (out_beats.size() !== exp_out.size()) $display("[TB] FAIL rand_count got=%0d exp=%0d", out_beats.size(), exp_out.size()); else passes++;
      for (int i = 0; i < exp_out.size(); i++) begin
         got = (i < out_beats.size()) ? out_beats[i] : 'x;
         checks++; if (got !== exp_out[i]) $display("[TB] FAIL rand_beat[%0d] got=%h exp=%h", i, got, exp_out[i]); else passes++;
      end
   endtask

   initial begin
      checks   = 0;
      passes   = 0;
      i_rst    = 1'b1;
      i_tready = 1'b0;
      i_tvalid = '0;
      i_tlast  = '0;
      i_tdata  = '0;
      test_reset();
      test_single_port();
      test_contention();
      test_wrap();
      test_atomicity();
      test_backpressure();
      test_reset_mid_packet();
      for (int it = 0; it < 3; it++) test_random(it);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation watchdog expired");
   end

endmodule
